pacman_control: RTL and testbench

Player-side movement controller: the ghost controllers chase its position, and it in turn follows player key input.
- Latches the most recent key press as a pending turn and steps Pac-Man one pixel per move tick.
- Before each step, asks the maze map whether the target cell is a wall, using a req/ack handshake.
- Its x_out/y_out drive the ghosts' x_dest/y_dest; shape feeds the sprite renderer.

---
 rtl/pacman_control.sv | 171 +++++++++++++++++
 tb/tb_pacman_control.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pacman_control.sv
// Pac-Man movement controller: latches the latest key as a pending turn and steps one pixel per
// move tick, after checking the target cell against the maze map over a req/ack handshake.
module pacman_control #(
    parameter int unsigned  MOVE_DIV  = 2000000,
    parameter logic [7:0]   X_START   = 8'd80,
    parameter logic [6:0]   Y_START   = 7'd90,
    parameter logic [7:0]   X_MAX     = 8'd155,
    parameter logic [6:0]   Y_MAX     = 7'd115,
    parameter logic [24:0]  PAC_SHAPE = 25'b0111011110111001111001110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    output logic        map_req,
    output logic [7:0]  map_x,
    output logic [6:0]  map_y,
    input  logic        map_ack,
    input  logic        map_wall,
    output logic [7:0]  x_out,
    output logic [6:0]  y_out,
    output logic [2:0]  dir_out,
    output logic [24:0] shape
);

    localparam logic [2:0] DirRight = 3'b000;
    localparam logic [2:0] DirLeft  = 3'b001;
    localparam logic [2:0] DirDown  = 3'b010;
    localparam logic [2:0] DirUp    = 3'b011;
    localparam logic [2:0] DirStop  = 3'b100;

    localparam int unsigned CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CW-1:0] CntLast = CW'(MOVE_DIV - 1);

    typedef enum logic [1:0] {StWait, StQPend, StQCur, StStep} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    x_q, x_d, mx_q, mx_d, tgt_x;
    logic [6:0]    y_q, y_d, my_q, my_d, tgt_y;
    logic [2:0]    dir_q, dir_d, pend_q, pend_d, qdir;
    logic          req_q, req_d, tgt_ok, tick;

    assign tick = (cnt_q == CntLast);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    // Q_PEND probes the pending turn; every other state works on the current heading.
    assign qdir = (state_q == StQPend) ? pend_q : dir_q;

    always_comb begin
        tgt_x  = x_q;
        tgt_y  = y_q;
        tgt_ok = 1'b1;
        case (qdir)
            DirRight: begin tgt_x = x_q + 8'd1; tgt_ok = (x_q < X_MAX);  end
            DirLeft:  begin tgt_x = x_q - 8'd1; tgt_ok = (x_q != 8'd0);  end
            DirDown:  begin tgt_y = y_q + 7'd1; tgt_ok = (y_q < Y_MAX);  end
            DirUp:    begin tgt_y = y_q - 7'd1; tgt_ok = (y_q != 7'd0);  end
            default:  tgt_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        req_d   = req_q;
        mx_d    = mx_q;
        my_d    = my_q;

        case (state_q)
            StWait: begin
                if (tick) begin
                    if (pend_q != DirStop && pend_q != dir_q) state_d = StQPend;
                    else if (dir_q != DirStop)                state_d = StQCur;
                end
            end
            StQPend: begin
                if (!req_q) begin
                    if (!tgt_ok) begin
                        state_d = StQCur;
                    end else begin
                        req_d = 1'b1;
                        mx_d  = tgt_x;
                        my_d  = tgt_y;
                    end
                end else if (map_ack) begin
                    req_d = 1'b0;
                    if (!map_wall) begin
                        dir_d   = pend_q;
                        pend_d  = DirStop;
                        state_d = StStep;
                    end else begin
                        state_d = StQCur;
                    end
                end
            end
            StQCur: begin
                if (dir_q == DirStop) begin
                    state_d = StWait;
                end else if (!req_q) begin
                    if (!tgt_ok) begin
                        dir_d   = DirStop;
                        state_d = StWait;
                    end else begin
                        req_d = 1'b1;
                        mx_d  = tgt_x;
                        my_d  = tgt_y;
                    end
                end else if (map_ack) begin
                    req_d = 1'b0;
                    if (!map_wall) begin
                        state_d = StStep;
                    end else begin
                        dir_d   = DirStop;
                        state_d = StWait;
                    end
                end
            end
            StStep: begin
                x_d     = tgt_x;
                y_d     = tgt_y;
                state_d = StWait;
            end
            default: state_d = StWait;
        endcase

        // Placed last so a fresh key press beats the clear of a consumed turn.
        if (key_up)         pend_d = DirUp;
        else if (key_down)  pend_d = DirDown;
        else if (key_left)  pend_d = DirLeft;
        else if (key_right) pend_d = DirRight;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWait;
            cnt_q   <= '0;
            x_q     <= X_START;
            y_q     <= Y_START;
            dir_q   <= DirStop;
            pend_q  <= DirStop;
            req_q   <= 1'b0;
            mx_q    <= 8'd0;
            my_q    <= 7'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
        end
    end

    assign map_req = req_q;
    assign map_x   = mx_q;
    assign map_y   = my_q;
    assign x_out   = x_q;
    assign y_out   = y_q;
    assign dir_out = dir_q;
    assign shape   = PAC_SHAPE;

endmodule

// File: tb/tb_pacman_control.sv
// Self-checking bench for pacman_control: key-priority vector table, directed corner-case
// sequences and a randomized run against a per-tick movement model.
module tb_pacman_control;

    localparam int unsigned DIV = 16;

    logic        clk = 1'b0, reset = 1'b1;
    logic        key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic        map_ack = 1'b0, map_wall = 1'b0;
    logic        map_req;
    logic [7:0]  map_x, x_out;
    logic [6:0]  map_y, y_out;
    logic [2:0]  dir_out;
    logic [24:0] shape;

    pacman_control #(.MOVE_DIV(DIV)) dut (
        .clk(clk), .reset(reset),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .map_req(map_req), .map_x(map_x), .map_y(map_y),
        .map_ack(map_ack), .map_wall(map_wall),
        .x_out(x_out), .y_out(y_out), .dir_out(dir_out), .shape(shape)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic wall [0:255][0:127];
    int fixed_dly = 0;
    bit rand_dly = 1'b0;
    int req_cnt = 0, cur_dly = 0, req_cycles = 0;
    logic [7:0] hx = 8'd0;
    logic [6:0] hy = 7'd0;
    int k = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Map model: answers after a configurable delay from the wall array.
    always @(negedge clk) begin
        map_ack = 1'b0;
        if (map_req) begin
            req_cycles++;
            if (req_cnt == 0) begin
                hx = map_x;
                hy = map_y;
                cur_dly = rand_dly ? int'($urandom_range(2)) : fixed_dly;
            end else begin
                chk("map_hold", {17'd0, map_x, map_y}, {17'd0, hx, hy});
            end
            if (req_cnt == cur_dly) begin
                map_ack  = 1'b1;
                map_wall = wall[map_x][map_y];
            end
            req_cnt++;
        end else begin
            req_cnt = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            k = (k + 1) % DIV;
        end
    endtask

    task automatic wait_phase(input int p);
        step(1);
        while (k != p) step(1);
    endtask

    task automatic do_reset();
        {key_up, key_down, key_left, key_right} = 4'b0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        k = 0;
    endtask

    task automatic pulse(input logic [3:0] keys);
        {key_up, key_down, key_left, key_right} = keys;
        step(1);
        {key_up, key_down, key_left, key_right} = 4'b0;
    endtask

    task automatic clear_walls();
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 128; y++) wall[x][y] = 1'b0;
    endtask

    // Reference model: whole-tick outcome from the movement rules.
    int mx, my, md, mp;

    function automatic bit free_cell(input int d, input int x, input int y,
                                     output int tx, output int ty);
        tx = x;
        ty = y;
        case (d)
            0: tx = x + 1;
            1: tx = x - 1;
            2: ty = y + 1;
            3: ty = y - 1;
            default: return 1'b0;
        endcase
        if (tx < 0 || tx > 155 || ty < 0 || ty > 115) return 1'b0;
        return !wall[tx][ty];
    endfunction

    task automatic model_tick();
        int tx, ty;
        if (mp != 4 && mp != md) begin
            if (free_cell(mp, mx, my, tx, ty)) begin
                md = mp;
                mp = 4;
                mx = tx;
                my = ty;
                return;
            end
        end
        if (md != 4) begin
            if (free_cell(md, mx, my, tx, ty)) begin
                mx = tx;
                my = ty;
            end else begin
                md = 4;
            end
        end
    endtask

    function automatic int prio(input logic [3:0] keys);
        if (keys[3]) return 3;
        if (keys[2]) return 2;
        if (keys[1]) return 1;
        return 0;
    endfunction

    typedef struct {
        logic [3:0] keys;
        logic [2:0] dir;
        logic [7:0] x;
        logic [6:0] y;
    } vec_t;

    vec_t vt[7];

    initial begin
        int xs[6], ys[6], ds[6];
        logic [3:0] rk;

        vt[0] = '{4'b0001, 3'b000, 8'd81, 7'd90};
        vt[1] = '{4'b0010, 3'b001, 8'd79, 7'd90};
        vt[2] = '{4'b0100, 3'b010, 8'd80, 7'd91};
        vt[3] = '{4'b1000, 3'b011, 8'd80, 7'd89};
        vt[4] = '{4'b1111, 3'b011, 8'd80, 7'd89};
        vt[5] = '{4'b0110, 3'b010, 8'd80, 7'd91};
        vt[6] = '{4'b0000, 3'b100, 8'd80, 7'd90};
        clear_walls();

        // Reset state and idle behaviour
        do_reset();
        chk("rst_x", x_out, 80);
        chk("rst_y", y_out, 90);
        chk("rst_dir", dir_out, 3'b100);
        chk("rst_req", map_req, 0);
        chk("shape", shape, 25'b0111011110111001111001110);
        req_cycles = 0;
        step(40);
        chk("idle_req", req_cycles, 0);
        chk("idle_x", x_out, 80);
        chk("idle_dir", dir_out, 3'b100);

        // Key priority table: one tick after a one-cycle key pulse
        for (int i = 0; i < 7; i++) begin
            do_reset();
            pulse(vt[i].keys);
            wait_phase(13);
            wait_phase(13);
            chk($sformatf("vec%0d_dir", i), dir_out, vt[i].dir);
            chk($sformatf("vec%0d_x", i), x_out, vt[i].x);
            chk($sformatf("vec%0d_y", i), y_out, vt[i].y);
        end

        // Right pulse: first query at (81,90), then one pixel per tick
        do_reset();
        pulse(4'b0001);
        wait_phase(13);
        for (int i = 0; i < 3; i++) begin
            wait_phase(13);
            chk("right_x", x_out, 81 + i);
            chk("right_dir", dir_out, 3'b000);
            if (i == 0) chk("right_q", {17'd0, hx, hy}, {17'd0, 8'd81, 7'd90});
        end

        // Held up-turn blocked by walls along y=89 until x=85
        for (int x = 0; x < 85; x++) wall[x][89] = 1'b1;
        xs = '{82, 83, 84, 85, 85, 85};
        ys = '{90, 90, 90, 90, 89, 88};
        ds = '{0, 0, 0, 0, 3, 3};
        do_reset();
        pulse(4'b0001);
        wait_phase(13);
        wait_phase(13);
        key_up = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_phase(13);
            chk("turn_x", x_out, xs[i]);
            chk("turn_y", y_out, ys[i]);
            chk("turn_dir", dir_out, ds[i]);
        end
        key_up = 1'b0;
        clear_walls();

        // Left edge: x reaches 0, then stop without a query
        do_reset();
        pulse(4'b0010);
        for (int n = 0; n < 100 && x_out != 8'd1; n++) wait_phase(13);
        chk("edge_x1", x_out, 1);
        wait_phase(13);
        chk("edge_x0", x_out, 0);
        chk("edge_dir0", dir_out, 3'b001);
        req_cycles = 0;
        wait_phase(13);
        chk("edge_noreq", req_cycles, 0);
        chk("edge_x", x_out, 0);
        chk("edge_dir", dir_out, 3'b100);

        // Stalled ack spanning a tick: one step only, extra tick dropped
        do_reset();
        pulse(4'b0001);
        wait_phase(13);
        wait_phase(13);
        fixed_dly = 24;
        wait_phase(13);
        chk("stall_req", map_req, 1);
        chk("stall_x", x_out, 81);
        wait_phase(13);
        chk("stall_step", x_out, 82);
        fixed_dly = 0;
        wait_phase(13);
        chk("stall_next", x_out, 83);

        // Reset in the middle of a query
        fixed_dly = 50;
        do_reset();
        pulse(4'b0001);
        for (int n = 0; n < 40 && !map_req; n++) step(1);
        chk("mid_req_seen", map_req, 1);
        do_reset();
        chk("mid_req", map_req, 0);
        chk("mid_x", x_out, 80);
        chk("mid_y", y_out, 90);
        chk("mid_dir", dir_out, 3'b100);
        fixed_dly = 0;
        wait_phase(13);
        wait_phase(13);
        chk("mid_pend", dir_out, 3'b100);
        chk("mid_pend_x", x_out, 80);

        // Randomized walk against the model
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 128; y++) wall[x][y] = ($urandom_range(3) == 0);
        rand_dly = 1'b1;
        do_reset();
        mx = 80; my = 90; md = 4; mp = 4;
        for (int p = 0; p < 150; p++) begin
            wait_phase(13);
            chk("rnd_x", x_out, mx);
            chk("rnd_y", y_out, my);
            chk("rnd_dir", dir_out, md);
            rk = ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'b0;
            if (rk != 4'b0) mp = prio(rk);
            pulse(rk);
            model_tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
